// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 byte memory responder (0x03 read, 0x02 write).
// Define SPI_RESP_SYNC_EN to add 2-flop synchronizers on sclk/cs_n/mosi for asynchronous initiators.
module spi_mem_responder #(
  parameter int MEM_BYTES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         busy,
  output logic                         wr_pulse,
  output logic [$clog2(MEM_BYTES)-1:0] wr_addr,
  output logic [7:0]                   wr_data
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, RD_DATA = 3'd3, WR_DATA = 3'd4, IGNORE = 3'd5;
  logic [2:0] state, in_q;
  logic sclk_d, cs_d, is_wr, rise, fall, cs_fall, cs_rise;
  logic [4:0] bit_cnt;
  logic [7:0] shreg, nx;
  logic [AW-1:0] ptr;
  logic [7:0] mem [MEM_BYTES];
  // cs history resets low so a cs_n already low at reset release is never seen as a fresh fall
`ifdef SPI_RESP_SYNC_EN
  logic [2:0] in_meta;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_meta <= '0;
      in_q <= '0;
    end else begin
      in_meta <= {sclk, cs_n, mosi};
      in_q <= in_meta;
    end
  end
`else
  always_ff @(posedge clk) in_q <= !rst_n ? 3'b000 : {sclk, cs_n, mosi};
`endif
  assign nx = {shreg[6:0], in_q[0]};
  assign rise = in_q[2] & ~sclk_d;
  assign fall = ~in_q[2] & sclk_d;
  assign cs_fall = ~in_q[1] & cs_d;
  assign cs_rise = in_q[1] & ~cs_d;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      miso <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      ptr <= '0;
      is_wr <= 1'b0;
      sclk_d <= 1'b0;
      cs_d <= 1'b0;
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= '0;
    end else begin
      sclk_d <= in_q[2];
      cs_d <= in_q[1];
      wr_pulse <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
        miso <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            shreg <= nx;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              state <= (nx == 8'h03 || nx == 8'h02) ? ADDR : IGNORE;
              is_wr <= nx == 8'h02;
              bit_cnt <= '0;
            end
          end
          ADDR: if (rise) begin
            ptr <= {ptr[AW-2:0], in_q[0]};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              state <= is_wr ? WR_DATA : RD_DATA;
              bit_cnt <= '0;
            end
          end
          RD_DATA: if (fall) begin
            miso <= mem[ptr][3'd7 - bit_cnt[2:0]];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt[2:0] == 3'd7) ptr <= ptr + AW'(1);
          end
          WR_DATA: if (rise) begin
            shreg <= nx;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt[2:0] == 3'd7) begin
              mem[ptr] <= nx;
              wr_pulse <= 1'b1;
              wr_addr <= ptr;
              wr_data <= nx;
              ptr <= ptr + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: randomized SPI initiator against a byte-array memory model.
module tb_spi_mem_responder;
  logic clk = 1'b0, rst_n, sclk, cs_n, mosi;
  logic miso, busy, wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int n_pass = 0, n_total = 0, hp = 2;
  logic [7:0] model [16];
  logic [11:0] wq [$];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];

  spi_mem_responder #(.MEM_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .busy(busy), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && wr_pulse) wq.push_back({wr_addr, wr_data});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic bit_io(input logic b, output logic r);
    mosi = b;
    repeat (hp) @(negedge clk);
    sclk = 1'b1;
    r = miso;
    repeat (hp) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic begin_txn(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    xfer(cmd, r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
  endtask

  task automatic end_txn();
    repeat (hp) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input logic [23:0] a);
    logic [7:0] r;
    begin_txn(8'h02, a);
    foreach (txq[i]) begin
      xfer(txq[i], r);
      model[(int'(a[3:0]) + i) % 16] = txq[i];
    end
    end_txn();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] r;
    rxq.delete();
    begin_txn(8'h03, a);
    repeat (n) begin
      xfer(8'h00, r);
      rxq.push_back(r);
    end
    end_txn();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    foreach (model[i]) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    n_total++;
    if ({miso, busy, wr_pulse, wr_addr, wr_data} !== 15'd0) $display("FAIL reset_outputs: got %h required 0", {miso, busy, wr_pulse, wr_addr, wr_data});
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [7:0] r;
    wq.delete();
    txq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    begin_txn(8'h02, 24'h000004);
    foreach (txq[i]) begin
      xfer(txq[i], r);
      model[(4 + i) % 16] = txq[i];
    end
    repeat (hp) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_hold: got %b required 1", busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL busy_drop: got %b required 0", busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (wq.size() != 4) $display("FAIL write_count: got %0d required 4", wq.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      n_total++;
      if (wq[i] !== {4'(4 + i), txq[i]}) $display("FAIL write_pulse%0d: got %h required %h", i, wq[i], {4'(4 + i), txq[i]});
      else n_pass++;
    end
  endtask

  task automatic test_read();
    do_read(24'h000004, 4);
    n_total++;
    if ({rxq[0], rxq[1], rxq[2], rxq[3]} !== 32'hDEADBEEF) $display("FAIL read_deadbeef: got %h required deadbeef", {rxq[0], rxq[1], rxq[2], rxq[3]});
    else n_pass++;
    n_total++;
    if ({miso, busy} !== 2'b00) $display("FAIL read_end: got miso,busy=%b required 00", {miso, busy});
    else n_pass++;
  endtask

  task automatic test_wrap();
    wq.delete();
    txq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(24'h00000E);
    n_total++;
    if (wq.size() != 4) $display("FAIL wrap_count: got %0d required 4", wq.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      n_total++;
      if (wq[i] !== {4'((14 + i) % 16), txq[i]}) $display("FAIL wrap_pulse%0d: got %h required %h", i, wq[i], {4'((14 + i) % 16), txq[i]});
      else n_pass++;
    end
    do_read(24'h00000F, 2);
    n_total++;
    if ({rxq[0], rxq[1]} !== 16'h2233) $display("FAIL wrap_read: got %h required 2233", {rxq[0], rxq[1]});
    else n_pass++;
    do_read(24'h00000E, 4);
    n_total++;
    if ({rxq[0], rxq[1], rxq[2], rxq[3]} !== 32'h11223344) $display("FAIL wrap_mem: got %h required 11223344", {rxq[0], rxq[1], rxq[2], rxq[3]});
    else n_pass++;
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] r;
    logic r1, seen;
    seen = 1'b0;
    wq.delete();
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    xfer(8'h9F, r);
    for (int i = 0; i < 32; i++) begin
      bit_io(1'($urandom), r1);
      seen = seen | r1 | miso;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL unknown_miso: got miso activity %b required 0", seen);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL unknown_busy: got %b required 1", busy);
    else n_pass++;
    end_txn();
    n_total++;
    if ({busy, wq.size() != 0} !== 2'b00) $display("FAIL unknown_end: got busy=%b pulses=%0d required 0/0", busy, wq.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] r;
    logic r1;
    wq.delete();
    begin_txn(8'h02, 24'h000000);
    xfer(8'hAB, r);
    model[0] = 8'hAB;
    bit_io(1'b1, r1); bit_io(1'b1, r1); bit_io(1'b0, r1); bit_io(1'b0, r1);
    end_txn();
    n_total++;
    if (wq.size() != 1) $display("FAIL abort_count: got %0d required 1", wq.size());
    else n_pass++;
    n_total++;
    if (wq.size() > 0 && wq[0] !== 12'h0AB) $display("FAIL abort_pulse: got %h required 0ab", wq[0]);
    else n_pass++;
    do_read(24'h000000, 2);
    n_total++;
    if ({rxq[0], rxq[1]} !== {8'hAB, model[1]}) $display("FAIL abort_read: got %h required %h", {rxq[0], rxq[1]}, {8'hAB, model[1]});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic r1;
    begin_txn(8'h02, 24'h000008);
    xfer(8'h5A, r);
    xfer(8'hC3, r);
    bit_io(1'b1, r1); bit_io(1'b0, r1); bit_io(1'b1, r1); bit_io(1'b1, r1);
    wq.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    foreach (model[i]) model[i] = 8'h00;
    n_total++;
    if ({miso, busy, wr_pulse, wr_addr, wr_data} !== 15'd0) $display("FAIL midreset_outputs: got %h required 0", {miso, busy, wr_pulse, wr_addr, wr_data});
    else n_pass++;
    rst_n = 1'b1;
    bit_io(1'b0, r1); bit_io(1'b1, r1); bit_io(1'b1, r1); bit_io(1'b0, r1);
    xfer(8'h77, r);
    n_total++;
    if (busy !== 1'b0) $display("FAIL midreset_ignore: got busy=%b required 0", busy);
    else n_pass++;
    end_txn();
    n_total++;
    if (wq.size() != 0) $display("FAIL midreset_pulses: got %0d required 0", wq.size());
    else n_pass++;
    do_read(24'h000000, 16);
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (rxq[i] !== model[i]) $display("FAIL midreset_mem%0d: got %h required %h", i, rxq[i], model[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [23:0] a, ra;
    int n, rn;
    for (int it = 0; it < 8; it++) begin
      hp = $urandom_range(2, 4);
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      txq.delete();
      repeat (n) txq.push_back(8'($urandom));
      wq.delete();
      do_write(a);
      n_total++;
      if (wq.size() != n) $display("FAIL rand%0d_count: got %0d required %0d", it, wq.size(), n);
      else n_pass++;
      for (int i = 0; i < n && i < wq.size(); i++) begin
        n_total++;
        if (wq[i] !== {4'((int'(a[3:0]) + i) % 16), txq[i]}) $display("FAIL rand%0d_pulse%0d: got %h required %h", it, i, wq[i], {4'((int'(a[3:0]) + i) % 16), txq[i]});
        else n_pass++;
      end
      ra = 24'($urandom);
      rn = $urandom_range(1, 20);
      do_read(ra, rn);
      for (int i = 0; i < rn; i++) begin
        n_total++;
        if (rxq[i] !== model[(int'(ra[3:0]) + i) % 16]) $display("FAIL rand%0d_read%0d: got %h required %h", it, i, rxq[i], model[(int'(ra[3:0]) + i) % 16]);
        else n_pass++;
      end
    end
    hp = 2;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_unknown_cmd();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
